// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC, instruction fetch and IF/ID latch with load-use hazard detection
module if_id_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        ext_stall,
   input  logic        ex_mem2r,
   input  logic        ex_regw,
   input  logic [4:0]  ex_wreg,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic [5:0]  OpCode,
   output logic [5:0]  funct,
   output logic        nop,
   output logic [15:0] stall_cnt
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        rt_used;
   logic        rs_hit;
   logic        rt_hit;
   logic        load_use;
   logic        stall;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;

   assign OpCode = id_instr[31:26];
   assign funct  = id_instr[5:0];
   assign id_rs  = id_instr[25:21];
   assign id_rt  = id_instr[20:16];

   // R-type, beq, bne and sw read rt; everything else only reads rs
   always_comb begin
      rt_used = 1'b0;
      case (OpCode)
         6'b000000, 6'b000100, 6'b000101, 6'b101011: rt_used = 1'b1;
         default:                                    rt_used = 1'b0;
      endcase
   end

   assign rs_hit   = (ex_wreg == id_rs);
   assign rt_hit   = rt_used && (ex_wreg == id_rt);
   assign load_use = id_valid && ex_mem2r && ex_regw && (ex_wreg != 5'd0) && (rs_hit || rt_hit);
   assign stall    = ext_stall || load_use;
   assign nop      = !id_valid || load_use;

   // Redirect wins over any stall, so a stall only counts when no redirect is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= PC_RESET;
         id_instr  <= 32'd0;
         id_pc4    <= 32'd0;
         id_valid  <= 1'b0;
         stall_cnt <= 16'd0;
      end else if (redirect) begin
         pc       <= {redirect_pc[31:2], 2'b00};
         id_instr <= 32'd0;
         id_valid <= 1'b0;
      end else if (stall) begin
         if (stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end else begin
         pc       <= pc_plus4;
         id_instr <= imem_rdata;
         id_pc4   <= pc_plus4;
         id_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage with a behavioural front-end model
module tb_if_id_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ext_stall;
   logic        ex_mem2r;
   logic        ex_regw;
   logic [4:0]  ex_wreg;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic [5:0]  OpCode;
   logic [5:0]  funct;
   logic        nop;
   logic [15:0] stall_cnt;

   if_id_stage #(.PC_RESET(32'h0000_3000)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .ext_stall(ext_stall),
      .ex_mem2r(ex_mem2r), .ex_regw(ex_regw), .ex_wreg(ex_wreg),
      .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
      .OpCode(OpCode), .funct(funct), .nop(nop), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: a few fixed words, the rest a deterministic hash of the address
   function automatic logic [31:0] fetch(input logic [31:0] a);
      logic [31:0] h;
      logic [5:0]  op;
      h = (a * 32'h9E37_79B1) ^ (a >> 7);
      case (h[2:0])
         3'd0: op = 6'd0;
         3'd1: op = 6'd4;
         3'd2: op = 6'd5;
         3'd3: op = 6'd43;
         3'd4: op = 6'd35;
         3'd5: op = 6'd13;
         3'd6: op = 6'd15;
         default: op = 6'd2;
      endcase
      case (a)
         32'h0000_3000: fetch = 32'h3421_0005;
         32'h0000_3040: fetch = 32'h0022_1820;
         32'h0000_3044: fetch = 32'h3445_0001;
         32'h0000_3048: fetch = 32'hAC45_0000;
         default:       fetch = {op, 2'b00, h[10:8], 2'b00, h[13:11], h[31:16]};
      endcase
   endfunction

   assign imem_rdata = fetch(imem_addr);

   typedef struct {
      logic        nop;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      int          cnt;
   } exp_t;

   exp_t sb[$];
   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   int          m_cnt;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_pc = 32'h0000_3000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
   endtask

   // Called at a falling edge: drive inputs, predict, push, then wait for the next falling edge
   task automatic step(input logic rd, input logic [31:0] rpc, input logic es,
                       input logic mr, input logic rw, input logic [4:0] wr);
      exp_t e;
      logic [5:0] op;
      logic uses_rt, lu;
      redirect = rd; redirect_pc = rpc; ext_stall = es;
      ex_mem2r = mr; ex_regw = rw; ex_wreg = wr;
      op = m_instr[31:26];
      uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
      lu = m_valid && mr && rw && (wr != 0) &&
           ((wr == m_instr[25:21]) || (uses_rt && wr == m_instr[20:16]));
      e.nop = !m_valid || lu;
      if (rd) begin
         m_pc = rpc & ~32'd3; m_instr = 0; m_valid = 0;
      end else if (es || lu) begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
         m_instr = fetch(m_pc); m_pc = m_pc + 4; m_pc4 = m_pc; m_valid = 1;
      end
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_imem_addr"}, imem_addr, 32'h0000_3000);
      chk({tag, "_id_instr"}, id_instr, 32'd0);
      chk({tag, "_id_pc4"}, id_pc4, 32'd0);
      chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
      chk({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
      chk({tag, "_nop"}, {31'd0, nop}, 32'd1);
      chk({tag, "_opcode"}, {26'd0, OpCode}, 32'd0);
      chk({tag, "_funct"}, {26'd0, funct}, 32'd0);
   endtask

   // Monitor: nop is sampled before the edge, registered state just after it
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("nop", {31'd0, nop}, {31'd0, e.nop});
            @(posedge clk);
            #1;
            chk("imem_addr", imem_addr, e.pc);
            chk("id_instr", id_instr, e.instr);
            chk("id_pc4", id_pc4, e.pc4);
            chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
            chk("stall_cnt", {16'd0, stall_cnt}, e.cnt[31:0]);
            chk("opcode", {26'd0, OpCode}, {26'd0, e.instr[31:26]});
            chk("funct", {26'd0, funct}, {26'd0, e.instr[5:0]});
         end
      end
   end

   initial begin
      logic [31:0] rpc;
      rst_n = 1'b0;
      redirect = 0; redirect_pc = 0; ext_stall = 0; ex_mem2r = 0; ex_regw = 0; ex_wreg = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      idle_step();
      chk("first_fetch_instr", id_instr, 32'h3421_0005);
      chk("first_fetch_pc4", id_pc4, 32'h0000_3004);
      step(1'b1, 32'h0000_3043, 1'b0, 1'b0, 1'b0, 5'd0);
      chk("redirect_addr", imem_addr, 32'h0000_3040);
      idle_step();
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd2);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd5);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd5);
      idle_step();
      step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 5'd0);
      idle_step();
      chk("wrap_pc", imem_addr, 32'd0);
      chk("wrap_pc4", id_pc4, 32'd0);
      step(1'b1, 32'h0000_3040, 1'b0, 1'b0, 1'b0, 5'd0);
      idle_step();
      step(1'b1, 32'h0000_3100, 1'b0, 1'b1, 1'b1, 5'd2);
      idle_step();

      for (int i = 0; i < 3000; i++) begin
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step($urandom_range(0, 7) == 0, rpc, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)));
      end

      for (int i = 0; i < 70000; i++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      end
      chk("stall_saturated", {16'd0, stall_cnt}, 32'h0000_FFFF);

      ext_stall = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      idle_step();
      idle_step();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
